// File: rtl/fifo_burst_reader_if.sv
// Valid/ready stream carrying framed bursts out of fifo_burst_reader.
// The master drives data and framing markers; the slave returns ready.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/fifo_burst_reader.sv
// Drains a registered-read FIFO into fixed-length bursts on a valid/ready stream.
// A small buffer absorbs the one-cycle read latency so a stalled consumer never loses words.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_req,
  fifo_burst_reader_if.master   m,
  output logic                  busy,
  output logic                  burst_done
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [OCC_W:0]   DEPTH_X   = (OCC_W + 1)'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_next_s;
  logic [DATA_WIDTH-1:0] mem_r [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [OCC_W-1:0]      occ_r;
  logic                  inflight_r;
  logic [CNT_W-1:0]      rd_cnt_r;
  logic [CNT_W-1:0]      bc_r;
  logic                  burst_done_r;
  logic                  rd_req_s;
  logic                  busy_s;
  logic                  valid_s;
  logic                  pop_s;
  logic                  eop_accept_s;
  logic                  last_read_s;

  // Reads are throttled on occupancy plus the word already in flight, never on m.ready.
  assign valid_s      = (occ_r != {OCC_W{1'b0}});
  assign pop_s        = valid_s && m.ready;
  assign eop_accept_s = pop_s && (bc_r == LAST_BEAT);
  assign last_read_s  = rd_req_s && (rd_cnt_r == LAST_BEAT);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable && !fifo_empty) state_next_s = READ;
        else                       state_next_s = IDLE;
      end
      READ: begin
        if (last_read_s) state_next_s = DRAIN;
        else             state_next_s = READ;
      end
      DRAIN: begin
        if (eop_accept_s) begin
          if (enable && !fifo_empty) state_next_s = READ;
          else                       state_next_s = IDLE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  always_comb begin
    rd_req_s = 1'b0;
    busy_s   = 1'b0;
    case (state_r)
      IDLE: begin
        rd_req_s = 1'b0;
        busy_s   = 1'b0;
      end
      READ: begin
        rd_req_s = !fifo_empty &&
                   (({1'b0, occ_r} + {{OCC_W{1'b0}}, inflight_r}) < DEPTH_X);
        busy_s   = 1'b1;
      end
      DRAIN: begin
        rd_req_s = 1'b0;
        busy_s   = 1'b1;
      end
      default: begin
        rd_req_s = 1'b0;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Buffer, read/beat counters and the done pulse; reset discards everything in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      occ_r        <= {OCC_W{1'b0}};
      inflight_r   <= 1'b0;
      rd_cnt_r     <= {CNT_W{1'b0}};
      bc_r         <= {CNT_W{1'b0}};
      burst_done_r <= 1'b0;
    end else begin
      inflight_r   <= rd_req_s;
      burst_done_r <= eop_accept_s;
      if (rd_req_s) begin
        rd_cnt_r <= last_read_s ? {CNT_W{1'b0}} : rd_cnt_r + CNT_W'(1);
      end else begin
        rd_cnt_r <= rd_cnt_r;
      end
      if (inflight_r) begin
        mem_r[wr_ptr_r] <= fifo_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        bc_r     <= (bc_r == LAST_BEAT) ? {CNT_W{1'b0}} : bc_r + CNT_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
        bc_r     <= bc_r;
      end
      case ({inflight_r, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
    end
  end

  assign fifo_rd_req = rd_req_s;
  assign busy        = busy_s;
  assign burst_done  = burst_done_r;
  assign m.valid     = valid_s;
  assign m.data      = mem_r[rd_ptr_r];
  assign m.sop       = valid_s && (bc_r == {CNT_W{1'b0}});
  assign m.eop       = valid_s && (bc_r == LAST_BEAT);
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a registered-read FIFO model and a stream monitor.
module tb_fifo_burst_reader;
  localparam int DW = 16;
  localparam int BD = 4;

  logic          sys_clk    = 1'b0;
  logic          sys_rst_n  = 1'b0;
  logic          enable     = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = 16'h0000;
  logic          fifo_rd_req;
  logic          busy;
  logic          burst_done;

  fifo_burst_reader_if #(.DATA_WIDTH(DW)) m_if ();

  fifo_burst_reader #(.DATA_WIDTH(DW), .BURST_LEN(4), .BUF_DEPTH(BD)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_req(fifo_rd_req),
    .m          (m_if),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 sys_clk = ~sys_clk;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            outstanding = 0;
  int            done_cnt = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got_q[$];
  logic          got_sop[$];
  logic          got_eop[$];
  int            got_cyc[$];
  int            rd_cyc[$];
  logic          rd_smp;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = 16'h0000;

  // Monitor just before each rising edge, then advance the FIFO model on the edge.
  always begin
    @(negedge sys_clk);
    #4;
    cyc++;
    rd_smp = fifo_rd_req;
    if (!sys_rst_n) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (m_if.valid !== 1'b1 || m_if.data !== prev_data) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h, expected valid=1 data=%h", m_if.valid, m_if.data, prev_data);
        end
      end
      if (fifo_rd_req) begin
        checks++;
        if (fifo_empty !== 1'b0 || outstanding >= BD) begin
          errors++;
          $display("FAIL rd_guard: empty=%b occ+inflight=%0d, expected empty=0 and occ+inflight<%0d", fifo_empty, outstanding, BD);
        end
        outstanding++;
        rd_cyc.push_back(cyc);
      end
      if (m_if.valid && m_if.ready) begin
        got_q.push_back(m_if.data);
        got_sop.push_back(m_if.sop);
        got_eop.push_back(m_if.eop);
        got_cyc.push_back(cyc);
        outstanding--;
      end
      if (burst_done) done_cnt++;
      prev_stall = m_if.valid && !m_if.ready;
      prev_data  = m_if.data;
    end
    @(posedge sys_clk);
    if (rd_smp && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic clear_log();
    got_q.delete();
    got_sop.delete();
    got_eop.delete();
    got_cyc.delete();
    rd_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic push_words(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(first + 16'(i));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    m_if.ready = 1'b0;
    sys_rst_n  = 1'b0;
    cycles(3);
    checks++;
    if ({m_if.valid, m_if.sop, m_if.eop, fifo_rd_req, busy, burst_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid,sop,eop,rd_req,busy,done=%b, expected 000000",
               {m_if.valid, m_if.sop, m_if.eop, fifo_rd_req, busy, burst_done});
    end
    checks++;
    if (m_if.data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: got %h, expected 0000", m_if.data);
    end
    sys_rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_single_burst();
    logic [DW-1:0] exp_w;
    clear_log();
    push_words(16'h0001, 4);
    enable     = 1'b1;
    m_if.ready = 1'b1;
    cycles(16);
    checks++;
    if (rd_cyc.size() != 4 || rd_cyc[3] != rd_cyc[0] + 3) begin
      errors++;
      $display("FAIL single_rd: %0d reads, expected 4 on consecutive cycles", rd_cyc.size());
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL single_count: got %0d words, expected 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      exp_w = 16'h0001 + 16'(i);
      checks++;
      if (got_q[i] !== exp_w || got_sop[i] !== (i == 0) || got_eop[i] !== (i == 3) || got_cyc[i] != got_cyc[0] + i) begin
        errors++;
        $display("FAIL single_word[%0d]: got %h sop=%b eop=%b, expected %h sop=%b eop=%b back-to-back",
                 i, got_q[i], got_sop[i], got_eop[i], exp_w, (i == 0), (i == 3));
      end
    end
    checks++;
    if (got_cyc.size() == 0 || rd_cyc.size() == 0 || got_cyc[0] != rd_cyc[0] + 2) begin
      errors++;
      $display("FAIL single_latency: first word not accepted 2 cycles after first read");
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: burst_done pulses=%0d busy=%b, expected 1 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_w;
    clear_log();
    push_words(16'h0001, 8);
    enable     = 1'b1;
    m_if.ready = 1'b1;
    cycles(30);
    checks++;
    if (got_q.size() != 8 || done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d words %0d bursts, expected 8 words 2 bursts", got_q.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      exp_w = 16'h0001 + 16'(i);
      checks++;
      if (got_q[i] !== exp_w || got_sop[i] !== (i % 4 == 0) || got_eop[i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL b2b_word[%0d]: got %h sop=%b eop=%b, expected %h sop=%b eop=%b",
                 i, got_q[i], got_sop[i], got_eop[i], exp_w, (i % 4 == 0), (i % 4 == 3));
      end
    end
    checks++;
    if (rd_cyc.size() != 8 || rd_cyc[4] - rd_cyc[3] != 3) begin
      errors++;
      $display("FAIL b2b_gap: %0d reads, expected 8 with second burst 3 cycles after first ends", rd_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] exp_w;
    clear_log();
    push_words(16'h0001, 8);
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      m_if.ready = (i % 4 == 0) || (i % 4 == 3);
      @(negedge sys_clk);
    end
    m_if.ready = 1'b1;
    cycles(4);
    checks++;
    if (got_q.size() != 8 || done_cnt != 2) begin
      errors++;
      $display("FAIL bp_count: got %0d words %0d bursts, expected 8 words 2 bursts", got_q.size(), done_cnt);
    end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      exp_w = 16'h0001 + 16'(i);
      checks++;
      if (got_q[i] !== exp_w || got_sop[i] !== (i % 4 == 0) || got_eop[i] !== (i % 4 == 3)) begin
        errors++;
        $display("FAIL bp_word[%0d]: got %h sop=%b eop=%b, expected %h sop=%b eop=%b",
                 i, got_q[i], got_sop[i], got_eop[i], exp_w, (i % 4 == 0), (i % 4 == 3));
      end
    end
  endtask

  task automatic test_stall();
    clear_log();
    push_words(16'h0011, 2);
    enable     = 1'b1;
    m_if.ready = 1'b1;
    cycles(12);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 16'h0011 || got_sop[0] !== 1'b1 ||
        got_q[1] !== 16'h0012 || got_sop[1] !== 1'b0 || got_eop[1] !== 1'b0) begin
      errors++;
      $display("FAIL stall_partial: got %0d words, expected 0011(sop) 0012", got_q.size());
    end
    checks++;
    if (m_if.valid !== 1'b0 || busy !== 1'b1 || fifo_rd_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait: valid=%b busy=%b rd_req=%b, expected 0 1 0", m_if.valid, busy, fifo_rd_req);
    end
    push_words(16'h0013, 2);
    cycles(12);
    checks++;
    if (got_q.size() != 4 || got_q[2] !== 16'h0013 || got_q[3] !== 16'h0014 ||
        got_eop[3] !== 1'b1 || got_eop[2] !== 1'b0) begin
      errors++;
      $display("FAIL stall_resume: got %0d words, expected 0013 0014(eop)", got_q.size());
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done: pulses=%0d busy=%b, expected 1 and 0", done_cnt, busy);
    end
  endtask

  task automatic test_enable_drop();
    logic seen;
    clear_log();
    push_words(16'h0021, 8);
    enable     = 1'b1;
    m_if.ready = 1'b1;
    seen       = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (fifo_rd_req) seen = 1'b1;
    end
    enable = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL en_start: no read within 10 cycles, expected one");
    end
    cycles(25);
    checks++;
    if (got_q.size() != 4 || got_q[0] !== 16'h0021 || got_q[3] !== 16'h0024 || got_eop[3] !== 1'b1) begin
      errors++;
      $display("FAIL en_burst: got %0d words, expected 0021..0024 with eop", got_q.size());
    end
    checks++;
    if (rd_cyc.size() != 4 || busy !== 1'b0 || fifo_q.size() != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL en_idle: reads=%0d busy=%b left=%0d pulses=%0d, expected 4 0 4 1",
               rd_cyc.size(), busy, fifo_q.size(), done_cnt);
    end
    enable = 1'b1;
    cycles(20);
    checks++;
    if (got_q.size() != 8 || got_q[4] !== 16'h0025 || got_sop[4] !== 1'b1 ||
        got_q[7] !== 16'h0028 || got_eop[7] !== 1'b1 || done_cnt != 2) begin
      errors++;
      $display("FAIL en_resume: got %0d words %0d bursts, expected 8 words ending 0025(sop)..0028(eop)",
               got_q.size(), done_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    clear_log();
    push_words(16'h0031, 8);
    enable     = 1'b1;
    m_if.ready = 1'b0;
    seen       = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge sys_clk);
      if (m_if.valid) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ar_fill: no valid within 10 cycles, expected one");
    end
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({m_if.valid, m_if.sop, m_if.eop, fifo_rd_req, busy, burst_done} !== 6'b0 || m_if.data !== 16'h0000) begin
      errors++;
      $display("FAIL ar_outputs: valid,sop,eop,rd_req,busy,done=%b data=%h, expected all 0",
               {m_if.valid, m_if.sop, m_if.eop, fifo_rd_req, busy, burst_done}, m_if.data);
    end
    clear_log();
    cycles(2);
    sys_rst_n  = 1'b1;
    m_if.ready = 1'b1;
    cycles(20);
    checks++;
    if (got_q.size() != 5 || got_q[0] !== 16'h0034 || got_sop[0] !== 1'b1 ||
        got_q[3] !== 16'h0037 || got_eop[3] !== 1'b1 || got_q[4] !== 16'h0038 || got_sop[4] !== 1'b1) begin
      errors++;
      $display("FAIL ar_restart: got %0d words first=%h, expected 0034(sop)..0037(eop) then 0038(sop)",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'h0000);
    end
    checks++;
    if (done_cnt != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_state: pulses=%0d busy=%b, expected 1 and 1", done_cnt, busy);
    end
  endtask

  initial begin
    m_if.ready = 1'b0;
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_backpressure();
    test_stall();
    test_enable_drop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
